comparador_multi: RTL and testbench



---
 rtl/comparador_multi.sv | 71 +++++++
 tb/tb_comparador_multi.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/comparador_multi.sv
// Sequential multi-stage password comparator: checks one guess per cycle against
// the current stage's password, tracks wrong guesses and unlocks or locks out.
module comparador_multi #(
   parameter  int WIDTH    = 4,
   parameter  int STAGES   = 2,
   parameter  int MAX_TENT = 7,
   localparam int FASE_W   = (STAGES > 1) ? $clog2(STAGES) : 1,
   localparam int CNT_W    = $clog2(MAX_TENT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [STAGES*WIDTH-1:0]   senhas,
   input  logic [WIDTH-1:0]          tentativa,
   input  logic                      tentativa_valida,
   input  logic                      reiniciar,
   output logic [1:0]                resultado,
   output logic                      resultado_valido,
   output logic [FASE_W-1:0]         fase,
   output logic [CNT_W-1:0]          tentativas_erradas,
   output logic                      desbloqueado,
   output logic                      bloqueado
);

   typedef enum logic [1:0] {
      COMPARA   = 2'd0,
      ABERTO    = 2'd1,
      BLOQUEADO = 2'd2
   } estadoT;

   estadoT           estado;
   logic [WIDTH-1:0] senhaAtual;

   // Mux by equality so a non-power-of-two STAGES never indexes past senhas.
   always_comb begin
      senhaAtual = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (fase == FASE_W'(k)) senhaAtual = senhas[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || reiniciar) begin
         estado             <= COMPARA;
         resultado          <= 2'b00;
         resultado_valido   <= 1'b0;
         fase               <= '0;
         tentativas_erradas <= '0;
      end else begin
         resultado_valido <= 1'b0;
         if (estado == COMPARA && tentativa_valida) begin
            resultado_valido <= 1'b1;
            if (tentativa == senhaAtual) begin
               resultado <= 2'b10;
               if (fase == FASE_W'(STAGES - 1)) estado <= ABERTO;
               else                             fase   <= fase + FASE_W'(1);
            end else begin
               resultado <= (tentativa > senhaAtual) ? 2'b01 : 2'b00;
               if (tentativas_erradas < CNT_W'(MAX_TENT))
                  tentativas_erradas <= tentativas_erradas + CNT_W'(1);
               // Lockout coincides with the verdict of the error that hits the limit.
               if (tentativas_erradas >= CNT_W'(MAX_TENT - 1))
                  estado <= BLOQUEADO;
            end
         end
      end
   end

   assign desbloqueado = (estado == ABERTO);
   assign bloqueado    = (estado == BLOQUEADO);

endmodule

// File: tb/tb_comparador_multi.sv
// Directed bench for comparador_multi: three configurations sharing one clock.
module tb_comparador_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // A: WIDTH=4 STAGES=2 MAX_TENT=4
   logic       aRst, aValid, aRein;
   logic [7:0] aSenhas;
   logic [3:0] aTent;
   logic [1:0] aRes;
   logic       aResV, aFase, aDesb, aBloq;
   logic [2:0] aErr;

   // B: WIDTH=4 STAGES=2 MAX_TENT=3
   logic       bRst, bValid, bRein;
   logic [7:0] bSenhas;
   logic [3:0] bTent;
   logic [1:0] bRes;
   logic       bResV, bFase, bDesb, bBloq;
   logic [1:0] bErr;

   // C: WIDTH=3 STAGES=1 MAX_TENT=7
   logic       cRst, cValid, cRein;
   logic [2:0] cSenhas;
   logic [2:0] cTent;
   logic [1:0] cRes;
   logic       cResV, cFase, cDesb, cBloq;
   logic [2:0] cErr;

   comparador_multi #(.WIDTH(4), .STAGES(2), .MAX_TENT(4)) dutA (
      .clk(clk), .rst(aRst), .senhas(aSenhas), .tentativa(aTent),
      .tentativa_valida(aValid), .reiniciar(aRein), .resultado(aRes),
      .resultado_valido(aResV), .fase(aFase), .tentativas_erradas(aErr),
      .desbloqueado(aDesb), .bloqueado(aBloq));

   comparador_multi #(.WIDTH(4), .STAGES(2), .MAX_TENT(3)) dutB (
      .clk(clk), .rst(bRst), .senhas(bSenhas), .tentativa(bTent),
      .tentativa_valida(bValid), .reiniciar(bRein), .resultado(bRes),
      .resultado_valido(bResV), .fase(bFase), .tentativas_erradas(bErr),
      .desbloqueado(bDesb), .bloqueado(bBloq));

   comparador_multi #(.WIDTH(3), .STAGES(1), .MAX_TENT(7)) dutC (
      .clk(clk), .rst(cRst), .senhas(cSenhas), .tentativa(cTent),
      .tentativa_valida(cValid), .reiniciar(cRein), .resultado(cRes),
      .resultado_valido(cResV), .fase(cFase), .tentativas_erradas(cErr),
      .desbloqueado(cDesb), .bloqueado(cBloq));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packs {resultado, resultado_valido, fase, tentativas_erradas, desbloqueado, bloqueado}.
   function automatic logic [31:0] packA();
      return {22'd0, aRes, aResV, aFase, 1'b0, aErr, aDesb, aBloq};
   endfunction
   function automatic logic [31:0] packB();
      return {22'd0, bRes, bResV, bFase, 2'b0, bErr, bDesb, bBloq};
   endfunction
   function automatic logic [31:0] packC();
      return {22'd0, cRes, cResV, cFase, 1'b0, cErr, cDesb, cBloq};
   endfunction
   function automatic logic [31:0] exp(input logic [1:0] r, input logic v, input logic f,
                                       input logic [2:0] e, input logic d, input logic b);
      return {22'd0, r, v, f, 1'b0, e, d, b};
   endfunction

   initial begin
      aRst = 1'b1; aRein = 1'b0; aValid = 1'b0; aTent = '0; aSenhas = {4'd9, 4'd5};
      bRst = 1'b1; bRein = 1'b0; bValid = 1'b0; bTent = '0; bSenhas = {4'd9, 4'd5};
      cRst = 1'b1; cRein = 1'b0; cValid = 1'b0; cTent = '0; cSenhas = 3'd7;
      #1;
      tick();
      // Guess during reset is dropped.
      aValid = 1'b1; aTent = 4'd5;
      tick();
      chk("resetA", packA(), exp(2'b00, 0, 0, 3'd0, 0, 0));
      chk("resetB", packB(), exp(2'b00, 0, 0, 3'd0, 0, 0));
      chk("resetC", packC(), exp(2'b00, 0, 0, 3'd0, 0, 0));
      aRst = 1'b0; bRst = 1'b0; cRst = 1'b0; aValid = 1'b0;

      // ---- A: verdicts and unlock ----
      aValid = 1'b1; aTent = 4'd7;  tick();
      chk("A_gt7",  packA(), exp(2'b01, 1, 0, 3'd1, 0, 0));
      aTent = 4'd3;                 tick();
      chk("A_lt3",  packA(), exp(2'b00, 1, 0, 3'd2, 0, 0));
      aTent = 4'd5;                 tick();
      chk("A_eq5",  packA(), exp(2'b10, 1, 1, 3'd2, 0, 0));
      aValid = 1'b0; aTent = 4'd9;  tick();
      chk("A_idle", packA(), exp(2'b10, 0, 1, 3'd2, 0, 0));
      aValid = 1'b1; aTent = 4'd12; tick();
      chk("A_gt12", packA(), exp(2'b01, 1, 1, 3'd3, 0, 0));
      aTent = 4'd9;                 tick();
      chk("A_unlock", packA(), exp(2'b10, 1, 1, 3'd3, 1, 0));
      aTent = 4'd0;                 tick();
      chk("A_ignored", packA(), exp(2'b10, 0, 1, 3'd3, 1, 0));
      aValid = 1'b0;

      // ---- B: lockout and restart priority ----
      bValid = 1'b1; bTent = 4'd0; tick();
      chk("B_err1", packB(), exp(2'b00, 1, 0, 3'd1, 0, 0));
      tick();
      chk("B_err2", packB(), exp(2'b00, 1, 0, 3'd2, 0, 0));
      tick();
      chk("B_lock", packB(), exp(2'b00, 1, 0, 3'd3, 0, 1));
      bTent = 4'd5; tick();
      chk("B_ignored", packB(), exp(2'b00, 0, 0, 3'd3, 0, 1));
      bRein = 1'b1; bTent = 4'd5; tick();
      chk("B_restart", packB(), exp(2'b00, 0, 0, 3'd0, 0, 0));
      bRein = 1'b0; tick();
      chk("B_eqAfter", packB(), exp(2'b10, 1, 1, 3'd0, 0, 0));
      // Stage 1 password changes live; the new value is used for the next compare.
      bSenhas = {4'd2, 4'd5}; bTent = 4'd9; tick();
      chk("B_liveSenha", packB(), exp(2'b01, 1, 1, 3'd1, 0, 0));
      bValid = 1'b0;

      // ---- C: STAGES=1, WIDTH=3 boundaries ----
      cValid = 1'b1; cTent = 3'd6; tick();
      chk("C_lt6", packC(), exp(2'b00, 1, 0, 3'd1, 0, 0));
      cTent = 3'd7; tick();
      chk("C_unlock7", packC(), exp(2'b10, 1, 0, 3'd1, 1, 0));
      cValid = 1'b0; cRein = 1'b1; cSenhas = 3'd0; tick();
      chk("C_restart", packC(), exp(2'b00, 0, 0, 3'd0, 0, 0));
      cRein = 1'b0; cValid = 1'b1; cTent = 3'd0; tick();
      chk("C_eqZero", packC(), exp(2'b10, 1, 0, 3'd0, 1, 0));
      cValid = 1'b0; tick();
      chk("C_pulseOne", packC(), exp(2'b10, 0, 0, 3'd0, 1, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
